// File: rtl/imu_pkg.sv
// Shared types and constants for the IMU sampling controller.
package imu_pkg;

  typedef enum logic [3:0] {
    BOOT,
    ID_REQ,
    ID_WAIT,
    CFG_REQ,
    CFG_WAIT,
    IDLE,
    RD_REQ,
    RD_WAIT,
    PUBLISH,
    FAULT
  } state_t;

  // Register map of the sensor
  localparam logic [7:0] ADDR_WHOAMI = 8'h0F;
  localparam logic [7:0] ADDR_CTRL1  = 8'h10;
  localparam logic [7:0] ADDR_CTRL2  = 8'h11;
  localparam logic [7:0] ADDR_CTRL3  = 8'h12;
  localparam logic [7:0] ADDR_DATA0  = 8'h22;

  // Configuration written once after a successful ID check
  localparam logic [7:0] CFG_CTRL1 = 8'h60;
  localparam logic [7:0] CFG_CTRL2 = 8'h60;
  localparam logic [7:0] CFG_CTRL3 = 8'h44;

  localparam int NUM_CFG   = 3;
  localparam int NUM_BYTES = 12;

  function automatic logic [7:0] cfg_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_addr = ADDR_CTRL1;
      2'd1:    cfg_addr = ADDR_CTRL2;
      default: cfg_addr = ADDR_CTRL3;
    endcase
  endfunction

  function automatic logic [7:0] cfg_data(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_data = CFG_CTRL1;
      2'd1:    cfg_data = CFG_CTRL2;
      default: cfg_data = CFG_CTRL3;
    endcase
  endfunction

endpackage

// File: rtl/imu_timer.sv
// Modulo-PERIOD down-counter; tick pulses once every PERIOD enabled cycles.
module imu_timer import imu_pkg::*; #(
  parameter int PERIOD = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [W-1:0] count;

  // Counter starts at 0 after reset, so the first tick also lands after
  // exactly PERIOD enabled cycles (0 -> PERIOD-1 -> ... -> 1 -> 0).
  assign tick = en && ((PERIOD == 1) || (count == W'(1)));

  // Count down while enabled, reloading from zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == '0) ? W'(PERIOD - 1) : count - W'(1);
    end
  end

endmodule

// File: rtl/imu_ctrl.sv
// IMU controller: boot delay, WHO_AM_I check with retry, configuration
// writes, then periodic 12-byte read bursts published as six sample words.
module imu_ctrl import imu_pkg::*; #(
  parameter int         BOOT_WAIT     = 2500,
  parameter int         SAMPLE_PERIOD = 50000,
  parameter int         MAX_RETRY     = 3,
  parameter logic [7:0] WHOAMI_VAL    = 8'h6C
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  output logic [7:0]         spi_addr,
  output logic [7:0]         spi_wdata,
  output logic               spi_read,
  output logic               spi_enable,
  input  logic [7:0]         spi_rdata,
  input  logic               spi_done,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic signed [15:0] acc_x,
  output logic signed [15:0] acc_y,
  output logic signed [15:0] acc_z,
  output logic               sample_valid,
  output logic               id_ok,
  output logic               fault,
  output logic               overrun
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  state_t             state;
  logic [RETRY_W-1:0] retry_cnt;
  logic [1:0]         cfg_idx;
  logic [3:0]         byte_idx;
  logic [7:0]         shadow [NUM_BYTES];
  logic               pending;
  logic               boot_tick;
  logic               sample_tick;
  logic               sample_en;
  logic               burst_start;

  assign sample_en   = run && (state inside {IDLE, RD_REQ, RD_WAIT, PUBLISH});
  assign burst_start = (state == IDLE) && pending && run;

  imu_timer #(.PERIOD(BOOT_WAIT)) u_boot_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == BOOT),
    .tick    (boot_tick)
  );

  imu_timer #(.PERIOD(SAMPLE_PERIOD)) u_sample_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (sample_en),
    .tick    (sample_tick)
  );

  // Sample request latch; a second tick before the first is served is an overrun
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (sample_tick && pending) overrun <= 1'b1;
      if (sample_tick)            pending <= 1'b1;
      else if (burst_start)       pending <= 1'b0;
    end
  end

  // Main sequencer; SPI request fields are loaded on the edge entering a
  // *_REQ state so they are valid for the whole request and wait period.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= BOOT;
      retry_cnt    <= '0;
      cfg_idx      <= '0;
      byte_idx     <= '0;
      spi_addr     <= '0;
      spi_wdata    <= '0;
      spi_read     <= 1'b0;
      spi_enable   <= 1'b0;
      id_ok        <= 1'b0;
      fault        <= 1'b0;
      sample_valid <= 1'b0;
      gyro_x       <= '0;
      gyro_y       <= '0;
      gyro_z       <= '0;
      acc_x        <= '0;
      acc_y        <= '0;
      acc_z        <= '0;
      for (int i = 0; i < NUM_BYTES; i++) shadow[i] <= '0;
    end else begin
      spi_enable   <= 1'b0;
      sample_valid <= 1'b0;
      unique case (state)
        BOOT: begin
          if (boot_tick) begin
            state      <= ID_REQ;
            spi_enable <= 1'b1;
            spi_addr   <= ADDR_WHOAMI;
            spi_wdata  <= '0;
            spi_read   <= 1'b1;
          end
        end
        ID_REQ: state <= ID_WAIT;
        ID_WAIT: begin
          if (spi_done) begin
            if (spi_rdata == WHOAMI_VAL) begin
              id_ok      <= 1'b1;
              cfg_idx    <= '0;
              state      <= CFG_REQ;
              spi_enable <= 1'b1;
              spi_addr   <= cfg_addr(2'd0);
              spi_wdata  <= cfg_data(2'd0);
              spi_read   <= 1'b0;
            end else if ((32'(retry_cnt) + 32'd1) < 32'(MAX_RETRY)) begin
              retry_cnt  <= retry_cnt + RETRY_W'(1);
              state      <= ID_REQ;
              spi_enable <= 1'b1;
              spi_addr   <= ADDR_WHOAMI;
              spi_wdata  <= '0;
              spi_read   <= 1'b1;
            end else begin
              retry_cnt <= retry_cnt + RETRY_W'(1);
              fault     <= 1'b1;
              state     <= FAULT;
            end
          end
        end
        CFG_REQ: state <= CFG_WAIT;
        CFG_WAIT: begin
          if (spi_done) begin
            if (cfg_idx == 2'(NUM_CFG - 1)) begin
              state <= IDLE;
            end else begin
              cfg_idx    <= cfg_idx + 2'd1;
              state      <= CFG_REQ;
              spi_enable <= 1'b1;
              spi_addr   <= cfg_addr(cfg_idx + 2'd1);
              spi_wdata  <= cfg_data(cfg_idx + 2'd1);
              spi_read   <= 1'b0;
            end
          end
        end
        IDLE: begin
          if (pending && run) begin
            byte_idx   <= '0;
            state      <= RD_REQ;
            spi_enable <= 1'b1;
            spi_addr   <= ADDR_DATA0;
            spi_wdata  <= '0;
            spi_read   <= 1'b1;
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          if (spi_done) begin
            shadow[byte_idx] <= spi_rdata;
            if (byte_idx == 4'(NUM_BYTES - 1)) begin
              state <= PUBLISH;
            end else begin
              byte_idx   <= byte_idx + 4'd1;
              state      <= RD_REQ;
              spi_enable <= 1'b1;
              spi_addr   <= ADDR_DATA0 + {4'b0000, byte_idx + 4'd1};
              spi_wdata  <= '0;
              spi_read   <= 1'b1;
            end
          end
        end
        PUBLISH: begin
          gyro_x       <= $signed({shadow[1],  shadow[0]});
          gyro_y       <= $signed({shadow[3],  shadow[2]});
          gyro_z       <= $signed({shadow[5],  shadow[4]});
          acc_x        <= $signed({shadow[7],  shadow[6]});
          acc_y        <= $signed({shadow[9],  shadow[8]});
          acc_z        <= $signed({shadow[11], shadow[10]});
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        FAULT: state <= FAULT;
        default: state <= BOOT;
      endcase
    end
  end

endmodule
